// File: rtl/seq_muldiv_unit.sv
// Iterative unsigned arithmetic unit: add, sub, shift-add multiply and
// restoring divide. The operation is launched with start, busy covers the
// whole operation, and done pulses for one cycle when the result is valid.
module seq_muldiv_unit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]         op_reg;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quot_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic [2*WIDTH-1:0] result_reg;
    logic [WIDTH-1:0]   remainder_reg;
    logic               dbz_reg;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     shifted_rem;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_next;
    logic               last_iter;
    logic               long_op;

    // One multiply / divide iteration computed from the current registers.
    // quot_reg starts out holding the dividend and shifts it out MSB-first
    // while quotient bits shift in from the bottom.
    always_comb begin
        acc_next    = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
        shifted_rem = {rem_reg, quot_reg[WIDTH-1]};
        rem_next    = shifted_rem[WIDTH-1:0];
        quot_next   = {quot_reg[WIDTH-2:0], 1'b0};
        if (shifted_rem >= {1'b0, divisor_reg}) begin
            rem_next  = WIDTH'(shifted_rem - {1'b0, divisor_reg});
            quot_next = {quot_reg[WIDTH-2:0], 1'b1};
        end
        last_iter = (count_reg == CW'(1));
        long_op   = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = long_op ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_reg        <= '0;
            count_reg     <= '0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            rem_reg       <= '0;
            quot_reg      <= '0;
            divisor_reg   <= '0;
            result_reg    <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg        <= op;
                        count_reg     <= '0;
                        acc_reg       <= '0;
                        mcand_reg     <= {{WIDTH{1'b0}}, a};
                        mplier_reg    <= b;
                        rem_reg       <= '0;
                        quot_reg      <= a;
                        divisor_reg   <= b;
                        result_reg    <= '0;
                        remainder_reg <= '0;
                        dbz_reg       <= 1'b0;
                        case (op)
                            OP_ADD: result_reg <= {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
                            OP_SUB: result_reg <= {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
                            OP_MUL: count_reg  <= CW'(WIDTH);
                            default: begin
                                if (b == '0) begin
                                    result_reg    <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                    remainder_reg <= a;
                                    dbz_reg       <= 1'b1;
                                end else begin
                                    count_reg <= CW'(WIDTH);
                                end
                            end
                        endcase
                    end
                end
                RUN: begin
                    count_reg <= count_reg - CW'(1);
                    if (op_reg == OP_MUL) begin
                        acc_reg    <= acc_next;
                        mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                        mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                        if (last_iter) begin
                            result_reg <= acc_next;
                        end
                    end else begin
                        rem_reg  <= rem_next;
                        quot_reg <= quot_next;
                        if (last_iter) begin
                            result_reg    <= {{WIDTH{1'b0}}, quot_next};
                            remainder_reg <= rem_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign result      = result_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed testbench for seq_muldiv_unit (WIDTH=8). Inputs change and
// outputs are sampled 1ns after the rising edge.
module tb_seq_muldiv_unit;

    localparam int W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic [W-1:0]     remainder;
    logic             div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge, then count cycles after the accepting edge
    // until done is seen (cycles = -1 if it never comes). busy_ok reports
    // whether busy stayed high from accept through the done cycle.
    task automatic run_op(input logic [1:0] opc, input logic [W-1:0] av,
                          input logic [W-1:0] bv, output int cycles,
                          output bit busy_ok);
        start = 1'b1; op = opc; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        cycles  = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                cycles = n;
                break;
            end
            @(posedge clk); #1;
        end
        $display("op=%0d a=%0d b=%0d -> result=%h remainder=%0d dbz=%0b cycles=%0d",
                 opc, av, bv, result, remainder, div_by_zero, cycles);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got=%h exp=0000", result); end
        checks++; if (remainder !== 8'h00) begin errors++; $display("FAIL reset_remainder got=%h exp=00", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        reset = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_mul();
        int cyc; bit bok;
        run_op(2'b10, 8'd255, 8'd255, cyc, bok);
        checks++; if (cyc != 9) begin errors++; $display("FAIL mul_latency got=%0d exp=9", cyc); end
        checks++; if (!bok) begin errors++; $display("FAIL mul_busy got=0 exp=1"); end
        checks++; if (result !== 16'hFE01) begin errors++; $display("FAIL mul_result got=%h exp=fe01", result); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL mul_remainder got=%0d exp=0", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL mul_dbz got=%b exp=0", div_by_zero); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mul_idle got busy=%b done=%b exp=0/0", busy, done); end
        checks++; if (result !== 16'hFE01) begin errors++; $display("FAIL mul_hold got=%h exp=fe01", result); end
    endtask

    task automatic test_div();
        int cyc; bit bok;
        run_op(2'b11, 8'd200, 8'd7, cyc, bok);
        checks++; if (cyc != 9) begin errors++; $display("FAIL div_latency got=%0d exp=9", cyc); end
        checks++; if (result !== 16'h001C) begin errors++; $display("FAIL div_quot got=%h exp=001c", result); end
        checks++; if (remainder !== 8'd4) begin errors++; $display("FAIL div_rem got=%0d exp=4", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_dbz got=%b exp=0", div_by_zero); end
        @(posedge clk); #1;
        run_op(2'b11, 8'd5, 8'd9, cyc, bok);
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL div_small_quot got=%h exp=0000", result); end
        checks++; if (remainder !== 8'd5) begin errors++; $display("FAIL div_small_rem got=%0d exp=5", remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_by_zero();
        int cyc; bit bok;
        run_op(2'b11, 8'd13, 8'd0, cyc, bok);
        checks++; if (cyc != 1) begin errors++; $display("FAIL dbz_latency got=%0d exp=1", cyc); end
        checks++; if (result !== 16'h00FF) begin errors++; $display("FAIL dbz_result got=%h exp=00ff", result); end
        checks++; if (remainder !== 8'd13) begin errors++; $display("FAIL dbz_rem got=%0d exp=13", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
        @(posedge clk); #1;
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_hold got=%b exp=1", div_by_zero); end
        run_op(2'b00, 8'd200, 8'd100, cyc, bok);
        checks++; if (cyc != 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", cyc); end
        checks++; if (result !== 16'h012C) begin errors++; $display("FAIL add_result got=%h exp=012c", result); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL add_dbz_clear got=%b exp=0", div_by_zero); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL add_rem got=%0d exp=0", remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        int cyc; bit bok;
        run_op(2'b01, 8'd5, 8'd7, cyc, bok);
        checks++; if (cyc != 1) begin errors++; $display("FAIL sub_latency got=%0d exp=1", cyc); end
        checks++; if (result !== 16'hFFFE) begin errors++; $display("FAIL sub_neg got=%h exp=fffe", result); end
        @(posedge clk); #1;
        run_op(2'b01, 8'd9, 8'd4, cyc, bok);
        checks++; if (result !== 16'h0005) begin errors++; $display("FAIL sub_pos got=%h exp=0005", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int n;
        int extra_done;
        start = 1'b1; op = 2'b10; a = 8'd12; b = 8'd11;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        repeat (3) begin @(posedge clk); #1; n++; end
        start = 1'b1; op = 2'b00; a = 8'd99; b = 8'd77;
        @(posedge clk); #1;
        n++;
        start = 1'b0; a = 8'd1; b = 8'd2;
        while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        $display("op=2 a=12 b=11 (start pulsed during RUN) -> result=%h cycles=%0d", result, n);
        checks++; if (n != 9) begin errors++; $display("FAIL ignore_latency got=%0d exp=9", n); end
        checks++; if (result !== 16'h0084) begin errors++; $display("FAIL ignore_result got=%h exp=0084", result); end
        // A start pulse in the DONE cycle must also be dropped.
        start = 1'b1; op = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) extra_done++;
            @(posedge clk); #1;
        end
        checks++; if (extra_done != 0) begin errors++; $display("FAIL ignore_extra_activity got=%0d exp=0", extra_done); end
        checks++; if (result !== 16'h0084) begin errors++; $display("FAIL ignore_hold got=%h exp=0084", result); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit bok;
        start = 1'b1; op = 2'b10; a = 8'd3; b = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        $display("reset asserted mid-multiply");
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got=%b exp=0", done); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL midreset_result got=%h exp=0000", result); end
        // start coincident with reset is lost.
        reset = 1'b0; start = 1'b1; op = 2'b10; a = 8'd3; b = 8'd3;
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        $display("start coincident with reset");
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_busy got=%b exp=0", busy); end
        run_op(2'b10, 8'd37, 8'd41, cyc, bok);
        checks++; if (cyc != 9) begin errors++; $display("FAIL post_reset_latency got=%0d exp=9", cyc); end
        checks++; if (result !== 16'h05ED) begin errors++; $display("FAIL post_reset_result got=%h exp=05ed", result); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_sub();
        test_busy_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_muldiv_unit.md
Name: seq_muldiv_unit

Overview:
- Parametrised iterative arithmetic unit: add, subtract, multiply and divide with remainder on two WIDTH-bit unsigned operands.
- Operands are accepted with a start/busy/done handshake.
- Multiply runs shift-add and divide runs restoring subtraction, one bit per clock, so no loop-breaking registers or external muxing are needed.
- Sits between the operand registers fed from ROM and the result/remainder registers of the top-level system.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH bits, remainder is WIDTH bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 add, 01 sub, 10 mul, 11 div
- a  input  WIDTH  operand A (dividend for div)
- b  input  WIDTH  operand B (divisor for div)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result/remainder become valid
- result  output  2*WIDTH  sum, difference, product, or zero-extended quotient
- remainder  output  WIDTH  div remainder; 0 for all other ops
- div_by_zero  output  1  set when div with b==0; cleared on next accepted start

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; busy, done, div_by_zero = 0; result, remainder = 0; iteration counter = 0. Reset overrides everything, including mid-operation.
- States: IDLE, RUN, DONE.
- IDLE, start==1 at edge E0:
  - Latch a, b, op into internal registers.
  - Clear div_by_zero, remainder and result.
  - busy=1 after E0.
  - Add/sub, or div with b==0: next state DONE.
  - Mul, or div with b!=0: next state RUN with counter=WIDTH.
- RUN: one iteration per edge; counter decrements; at the edge where counter reaches 0, next state is DONE.
- Mul:
  - Iteration k adds the shifted multiplicand to the accumulator if the current multiplier bit is 1.
  - Final product = a*b exactly in 2*WIDTH bits.
- Div:
  - Restoring: shift partial remainder left, bring in the next dividend bit MSB-first, subtract b if no borrow, set the quotient bit.
  - quotient = a/b, remainder = a%b.
  - a<b yields quotient 0, remainder a.
- DONE:
  - done=1 for exactly this cycle; busy=1.
  - result/remainder are valid and stable.
  - Next state is IDLE unconditionally; start is ignored in DONE.
- Latency from accepting edge E0:
  - add/sub and div-by-zero: done high in the cycle after E1.
  - mul/div: done high in the cycle after E(WIDTH+1).
- Add: result = a + b zero-extended; the carry lands in bit WIDTH.
- Sub: result = (a - b) mod 2^(2*WIDTH), i.e. sign-extended two's complement when a<b.
- Div by zero: result = {WIDTH zeros, WIDTH ones}, remainder = a, div_by_zero = 1.
- Outputs hold their DONE values through IDLE until the next start is accepted.
- start asserted while busy (RUN or DONE) is ignored and not queued; changes on a/b/op during RUN do not affect the operation in progress.
- start asserted in the same cycle that reset is low: reset wins, the request is lost.
- Unused ops: none; all 4 codes are defined.

Test Plan:
- WIDTH=8, op=10, a=255, b=255, start pulse -> busy for 9 cycles, done pulse in cycle 9 after accept, result=16'hFE01, remainder=0, div_by_zero=0.
- op=11, a=200, b=7 -> after WIDTH+1 cycles result=16'h001C (28), remainder=4, div_by_zero=0; repeat with a=5, b=9 -> result=0, remainder=5.
- op=11, a=13, b=0 -> done in the cycle after E1, result=16'h00FF, remainder=13, div_by_zero=1; then op=00, a=200, b=100 -> result=16'h012C, div_by_zero=0.
- op=01, a=5, b=7 -> done in the cycle after E1, result=16'hFFFE; op=01, a=9, b=4 -> result=16'h0005.
- Start mul 12*11, then pulse start with op=00 and change a/b during RUN -> second request ignored, result=16'h0084, busy drops after the single done pulse.
- Start mul, drive reset low at iteration 4 for one edge -> busy=0, done=0, result=0, state IDLE; a new start then completes normally with a correct product.
